// File: rtl/boid_state_packer.sv
// boid_state_packer
// Takes one boid record (x, y, vx, vy in signed fix15) per handshake, narrows
// each field to a saturated FIELD_W-bit fixed-point value and writes the record
// into the boid-state M10k as two packed words:
//   word0 = {y, x}   at address 2*idx
//   word1 = {vy, vx} at address 2*idx+1
// The read side sign-extends these fields back to fix15.
// A record takes three cycles: capture (IDLE), position write, velocity write.

module boid_state_packer #(
  parameter int FIELD_W   = 16,  // width of each packed signed field
  parameter int FRAC_KEEP = 4,   // fractional bits kept per field (0..15)
  parameter int N_BOIDS   = 32,  // boids per frame
  parameter int ADDR_W    = 6    // M10k address width, 2**ADDR_W >= 2*N_BOIDS
) (
  input  logic                   clk,
  input  logic                   reset,          // async, active-low
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_x,
  input  logic [31:0]            in_y,
  input  logic [31:0]            in_vx,
  input  logic [31:0]            in_vy,
  input  logic                   frame_restart,
  input  logic                   sat_clear,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [2*FIELD_W-1:0]   mem_wdata,
  output logic                   frame_done,
  output logic                   sat_flag
);

  // Right shift that drops the fix15 fractional bits we do not keep.
  localparam int SHIFT = 15 - FRAC_KEEP;
  localparam int IDX_W = (N_BOIDS > 1) ? $clog2(N_BOIDS) : 1;
  // Representable range of one packed field.
  localparam int F_MAX = (2 ** (FIELD_W - 1)) - 1;
  localparam int F_MIN = -(2 ** (FIELD_W - 1));
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BOIDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_POS = 2'd1,
    WR_VEL = 2'd2
  } state_e;

  // A narrowed field together with the flag saying it was clamped.
  typedef struct packed {
    logic               sat;
    logic [FIELD_W-1:0] val;
  } field_t;

  // Floor-shift a fix15 value down to the kept precision and clamp it into
  // the signed FIELD_W-bit range.
  function automatic field_t narrow(input logic [31:0] raw);
    logic signed [31:0] s;
    field_t             f;
    s     = $signed(raw) >>> SHIFT;
    f.sat = 1'b1;
    if (s > F_MAX) begin
      f.val = {1'b0, {(FIELD_W-1){1'b1}}};
    end else if (s < F_MIN) begin
      f.val = {1'b1, {(FIELD_W-1){1'b0}}};
    end else begin
      f.sat = 1'b0;
      f.val = FIELD_W'(s);
    end
    return f;
  endfunction

  // Registered state.
  state_e                 state_q,       state_d;
  logic [IDX_W-1:0]       idx_q,         idx_d;
  logic [2*FIELD_W-1:0]   vel_word_q,    vel_word_d;
  logic                   restart_pend_q, restart_pend_d;
  logic                   mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q,    mem_addr_d;
  logic [2*FIELD_W-1:0]   mem_wdata_q,   mem_wdata_d;
  logic                   frame_done_q,  frame_done_d;
  logic                   sat_flag_q,    sat_flag_d;

  // Combinational conversion of the incoming record.
  field_t fx, fy, fvx, fvy;
  logic   any_sat;
  logic   handshake;

  // Narrow all four incoming fields and flag any clamping.
  always_comb begin
    fx        = narrow(in_x);
    fy        = narrow(in_y);
    fvx       = narrow(in_vx);
    fvy       = narrow(in_vy);
    any_sat   = fx.sat | fy.sat | fvx.sat | fvy.sat;
    handshake = (state_q == IDLE) && in_valid;
  end

  // Next-state logic. The memory-port outputs are computed from the state
  // being entered so that they come straight off flops: word0 appears the
  // cycle after the handshake and word1 the cycle after that.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    vel_word_d     = vel_word_q;
    restart_pend_d = restart_pend_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;     // address and data hold while idle
    mem_wdata_d    = mem_wdata_q;
    frame_done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d        = WR_POS;
          mem_we_d       = 1'b1;
          mem_addr_d     = ADDR_W'({idx_q, 1'b0});
          mem_wdata_d    = {fy.val, fx.val};
          vel_word_d     = {fvy.val, fvx.val};
          // A restart arriving with the capture must not be undone by the
          // increment at the end of this record.
          restart_pend_d = frame_restart;
        end
      end
      WR_POS: begin
        state_d     = WR_VEL;
        mem_we_d    = 1'b1;
        // Derived from the captured address, not idx, so a restart in flight
        // cannot move the second half of this record.
        mem_addr_d  = mem_addr_q | ADDR_W'(1);
        mem_wdata_d = vel_word_q;
        if (frame_restart) restart_pend_d = 1'b1;
      end
      WR_VEL: begin
        state_d        = IDLE;
        restart_pend_d = 1'b0;
        if (frame_restart || restart_pend_q) begin
          idx_d = '0;                 // restart wins: no advance, no frame_done
        end else if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A restart always points the next record at index 0.
    if (frame_restart) idx_d = '0;
  end

  // Sticky saturation flag; a new saturating capture beats a clear.
  always_comb begin
    sat_flag_d = (sat_flag_q & ~sat_clear) | (handshake & any_sat);
  end

  // State and output registers; reset drops any in-flight record at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      vel_word_q     <= '0;
      restart_pend_q <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      frame_done_q   <= 1'b0;
      sat_flag_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q        <= state_d;
      idx_q          <= idx_d;
      vel_word_q     <= vel_word_d;
      restart_pend_q <= restart_pend_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      frame_done_q   <= frame_done_d;
      sat_flag_q     <= sat_flag_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_done = frame_done_q;
  assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_boid_state_packer.sv
// Testbench for boid_state_packer: directed sequence with a write scoreboard.
// Expected M10k writes are queued when a record is handed over and popped by
// a monitor that samples the write port on the falling clock edge.

module tb_boid_state_packer;

  localparam int FIELD_W   = 16;
  localparam int FRAC_KEEP = 4;
  localparam int N_BOIDS   = 32;
  localparam int ADDR_W    = 6;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [31:0]          in_x = '0, in_y = '0, in_vx = '0, in_vy = '0;
  logic                 frame_restart = 1'b0;
  logic                 sat_clear = 1'b0;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [2*FIELD_W-1:0] mem_wdata;
  logic                 frame_done;
  logic                 sat_flag;

  boid_state_packer #(
    .FIELD_W(FIELD_W), .FRAC_KEEP(FRAC_KEEP), .N_BOIDS(N_BOIDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_vx(in_vx), .in_vy(in_vy),
    .frame_restart(frame_restart), .sat_clear(sat_clear),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .frame_done(frame_done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               sb[$];
  int                tests = 0;
  int                fails = 0;
  int                fd_cnt = 0;
  int                cyc = 0;
  int                exp_idx = 0;
  int                hs_cyc = 0;
  logic              prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing: floor division by 2^(15-FRAC_KEEP), then clamp.
  // Returns {saturated, field}.
  function automatic logic [16:0] conv(input logic [31:0] v);
    longint lv, q, dv;
    dv = longint'(1) << (15 - FRAC_KEEP);
    lv = longint'($signed(v));
    q  = lv / dv;
    if ((lv % dv) != 0 && lv < 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  // Monitor: every write must match the scoreboard head; frame_done must
  // follow the write of the last address and coincide with in_ready.
  always @(negedge clk) begin
    if (mem_we) begin
      check("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
    if (frame_done) begin
      fd_cnt++;
      check("fd_after_last", {prev_we, prev_addr}, {1'b1, ADDR_W'(2*N_BOIDS-1)});
      check("fd_ready", in_ready, 1'b1);
    end
    prev_we   = mem_we;
    prev_addr = mem_addr;
  end

  // Wait (bounded) for a falling edge where the packer is idle.
  task automatic wait_ready();
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", in_ready, 1'b1);
  endtask

  // Present a record for one handshake and queue its expected writes.
  // in_valid is left high; the caller drops it when done.
  task automatic send_core(input logic [31:0] x, y, vx, vy,
                           input logic [31:0] w0, w1, input bit push_vel);
    wait_ready();
    in_x = x; in_y = y; in_vx = vx; in_vy = vy;
    in_valid = 1'b1;
    sb.push_back('{ADDR_W'(2*exp_idx), w0});
    if (push_vel) sb.push_back('{ADDR_W'(2*exp_idx+1), w1});
    exp_idx = (exp_idx == N_BOIDS-1) ? 0 : exp_idx + 1;
    hs_cyc  = cyc;
  endtask

  task automatic send(input logic [31:0] x, y, vx, vy);
    logic [16:0] cx, cy, cvx, cvy;
    cx = conv(x); cy = conv(y); cvx = conv(vx); cvy = conv(vy);
    send_core(x, y, vx, vy, {cy[15:0], cx[15:0]}, {cvy[15:0], cvx[15:0]}, 1'b1);
  endtask

  task automatic send_rand();
    send($urandom(), $urandom(), $urandom(), $urandom());
  endtask

  task automatic restart_idle();
    wait_ready();
    frame_restart = 1'b1;
    @(negedge clk);
    frame_restart = 1'b0;
    exp_idx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_before;
    int prev_hs;

    // ---- Reset: in_valid high must not be taken while reset is low.
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;

    // ---- Basic conversion and timing.
    send_core(32'h0000_8000, 32'hFFFF_8000, 32'h0000_4000, 32'h0,
              32'hFFF0_0010, 32'h0000_0008, 1'b1);
    @(negedge clk);                       // word0 on the port
    in_valid = 1'b0;
    check("busy_ready", in_ready, 1'b0);
    check("sat_clean", sat_flag, 1'b0);
    @(negedge clk);                       // word1 on the port
    check("busy_ready2", in_ready, 1'b0);
    @(negedge clk);
    check("ready_n3", in_ready, 1'b1);
    check("idle_we", mem_we, 1'b0);
    check("hold_addr", mem_addr, 1);
    check("hold_wdata", mem_wdata, 32'h0000_0008);

    // ---- Saturation and the sticky flag.
    send_core(32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0,
              32'h8000_7FFF, 32'h0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("sat_set", sat_flag, 1'b1);
    @(negedge clk);
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
    check("sat_cleared", sat_flag, 1'b0);
    wait_ready();
    sat_clear = 1'b1;                     // clear coincident with saturating capture
    send(32'h0, 32'h0, 32'h4000_0000, 32'h0);
    @(negedge clk);
    in_valid  = 1'b0;
    sat_clear = 1'b0;
    check("sat_set_wins", sat_flag, 1'b1);
    @(negedge clk);
    check("sat_sticky", sat_flag, 1'b1);
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;

    // ---- Tiny negative floors to -1 without saturating.
    send_core(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
              32'h0000_FFFF, 32'h0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("tiny_neg_nosat", sat_flag, 1'b0);

    // ---- Full frame back to back, plus the first record of the next frame.
    restart_idle();
    fd_before = fd_cnt;
    prev_hs   = 0;
    for (int i = 0; i < N_BOIDS + 1; i++) begin
      send_rand();
      if (i > 0) check("burst_spacing", hs_cyc - prev_hs, 3);
      prev_hs = hs_cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_ready();
    check("frame_done_once", fd_cnt - fd_before, 1);

    // ---- Restart during WR_POS of record 5.
    restart_idle();
    fd_before = fd_cnt;
    for (int i = 0; i < 6; i++) send_rand();  // record 5 -> addr 10,11
    @(negedge clk);                           // WR_POS of record 5
    in_valid      = 1'b0;
    frame_restart = 1'b1;
    exp_idx       = 0;
    @(negedge clk);
    frame_restart = 1'b0;
    send_rand();                              // -> addr 0,1
    @(negedge clk);
    in_valid = 1'b0;
    wait_ready();
    check("restart_no_fd", fd_cnt - fd_before, 0);

    // ---- Restart during WR_VEL of the last record suppresses frame_done.
    restart_idle();
    fd_before = fd_cnt;
    for (int i = 0; i < N_BOIDS; i++) send_rand();
    @(negedge clk);                           // WR_POS of record 31
    in_valid = 1'b0;
    @(negedge clk);                           // WR_VEL of record 31
    frame_restart = 1'b1;
    @(negedge clk);
    frame_restart = 1'b0;
    check("restart_last_fd", frame_done, 1'b0);
    check("restart_last_ready", in_ready, 1'b1);
    send_rand();                              // -> addr 0,1
    @(negedge clk);
    in_valid = 1'b0;
    wait_ready();
    check("restart_last_cnt", fd_cnt - fd_before, 0);

    // ---- Reset during WR_POS drops the velocity write.
    send_core(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
              32'h0040_0020, 32'h0, 1'b0);    // only word0 expected (addr 2)
    @(negedge clk);                           // word0 seen by the monitor
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_we", mem_we, 1'b0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_ready", in_ready, 1'b1);
    exp_idx = 0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    send(32'h0000_8000, 32'h0000_8000, 32'hFFFF_C000, 32'h0);  // -> addr 0,1
    @(negedge clk);
    in_valid = 1'b0;
    wait_ready();
    @(negedge clk);

    check("sb_empty", sb.size(), 0);
    check("fd_total", fd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
